seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the Alchitry Io 4-digit 7-segment display.

---
 rtl/seg_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display: double-buffered hex value,
// per-digit blank/drive slots, leading-zero suppression and frame-aligned commit.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DWELL  = 25000,
  parameter int unsigned BLANK  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic                  load,
  output logic                  load_ack,
  output logic                  frame_start,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     digit_n
);

  localparam int unsigned CNT_MAX    = (BLANK > DWELL) ? BLANK : DWELL;
  localparam int unsigned CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BUF_W      = 5 * DIGITS;
  localparam int unsigned BLANK_LAST = (BLANK > 0) ? BLANK - 1 : 0;

  typedef enum logic {S_BLANK, S_DRIVE} state_e;
  localparam state_e S_FIRST = (BLANK > 0) ? S_BLANK : S_DRIVE;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BUF_W-1:0]  shadow_q, shadow_d, active_q, active_d;
  logic              pending_q, pending_d, lz_q, lz_d;
  logic              slot_start_c, frame_c, commit_c;
  logic [4*DIGITS-1:0] val_c;
  logic [DIGITS-1:0] dpv_c, supp_c;
  logic [3:0]        nib_c;
  logic [6:0]        hex_seg_c;
  logic [6:0]        seg_n_d;
  logic              dp_n_d, load_ack_d, frame_start_d;
  logic [DIGITS-1:0] digit_n_d;

  // FSM state register: phase, cycle within phase, digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FIRST;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: BLANK phase then DRIVE phase, digit advances at end of DRIVE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == CW'(BLANK_LAST)) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == CW'(DWELL - 1)) begin
          state_d = S_FIRST;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
      end
    endcase
  end

  // Buffer handling: commit only at the first cycle of a frame
  always_comb begin
    slot_start_c = (state_q == S_FIRST) && (cnt_q == '0);
    frame_c      = slot_start_c && (idx_q == '0);
    commit_c     = frame_c && pending_q;
    active_d     = commit_c ? shadow_q : active_q;
    shadow_d     = load ? {value_in, dp_in} : shadow_q;
    pending_d    = load | (pending_q & ~commit_c);
    lz_d         = slot_start_c ? lz_en : lz_q;
  end

  assign val_c = active_d[BUF_W-1:DIGITS];
  assign dpv_c = active_d[DIGITS-1:0];
  assign nib_c = val_c[{idx_q, 2'b00} +: 4];

  // A digit is suppressed when it and every more-significant nibble are zero
  always_comb begin
    logic any_nz;
    any_nz = 1'b0;
    supp_c = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      any_nz    = any_nz | (val_c[4*i +: 4] != 4'h0);
      supp_c[i] = lz_d && (i > 0) && !any_nz;
    end
  end

  hex7segment u_hex (
    .nib_i  (nib_c),
    .seg_n_o(hex_seg_c)
  );

  // Output decode for the next registered pin values
  always_comb begin
    seg_n_d       = 7'h7F;
    dp_n_d        = 1'b1;
    digit_n_d     = '1;
    load_ack_d    = commit_c;
    frame_start_d = frame_c;
    if (state_q == S_DRIVE) begin
      seg_n_d = supp_c[idx_q] ? 7'h7F : hex_seg_c;
      dp_n_d  = ~dpv_c[idx_q];
      if (!supp_c[idx_q] || dpv_c[idx_q]) digit_n_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      lz_q        <= 1'b0;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      digit_n     <= '1;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      lz_q        <= lz_d;
      seg_n       <= seg_n_d;
      dp_n        <= dp_n_d;
      digit_n     <= digit_n_d;
      load_ack    <= load_ack_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// Hex nibble to active-low segments {g,f,e,d,c,b,a}.
module hex7segment (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);
  always_comb begin
    seg_n_o = 7'h7F;
    case (nib_i)
      4'h0: seg_n_o = 7'h40;
      4'h1: seg_n_o = 7'h79;
      4'h2: seg_n_o = 7'h24;
      4'h3: seg_n_o = 7'h30;
      4'h4: seg_n_o = 7'h19;
      4'h5: seg_n_o = 7'h12;
      4'h6: seg_n_o = 7'h02;
      4'h7: seg_n_o = 7'h78;
      4'h8: seg_n_o = 7'h00;
      4'h9: seg_n_o = 7'h10;
      4'hA: seg_n_o = 7'h08;
      4'hB: seg_n_o = 7'h03;
      4'hC: seg_n_o = 7'h46;
      4'hD: seg_n_o = 7'h21;
      4'hE: seg_n_o = 7'h06;
      default: seg_n_o = 7'h0E;
    endcase
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two builds (BLANK=2/DWELL=4 and BLANK=0/DWELL=1) driven
// with shared inputs and compared each cycle against a slot-arithmetic reference.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        lz_en, load;

  logic [6:0] seg0, seg1;
  logic       dp0, dp1, ack0, ack1, fs0, fs1;
  logic [3:0] dig0, dig1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(4), .DWELL(4), .BLANK(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .lz_en(lz_en),
    .load(load), .load_ack(ack0), .frame_start(fs0), .seg_n(seg0), .dp_n(dp0),
    .digit_n(dig0));

  seg_scan_ctrl #(.DIGITS(4), .DWELL(1), .BLANK(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in), .lz_en(lz_en),
    .load(load), .load_ack(ack1), .frame_start(fs1), .seg_n(seg1), .dp_n(dp1),
    .digit_n(dig1));

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state per build: edges since reset release, buffers, latched lz
  int         mk [2];
  logic [19:0] msh [2], mact [2];
  bit          mpend [2], mlz [2];
  logic [6:0]  exp_seg [2];
  logic        exp_dp [2], exp_ack [2], exp_fs [2];
  logic [3:0]  exp_dig [2];

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mk[u] = 0; msh[u] = '0; mact[u] = '0; mpend[u] = 0; mlz[u] = 0;
      exp_seg[u] = 7'h7F; exp_dp[u] = 1'b1; exp_dig[u] = 4'hF;
      exp_ack[u] = 1'b0; exp_fs[u] = 1'b0;
    end
  endtask

  task automatic model_step(input int u, input int b, input int w);
    int p, d;
    logic [15:0] v;
    logic [3:0]  dpv;
    bit sup;
    mk[u]++;
    p = (mk[u] - 1) % (b + w);
    d = ((mk[u] - 1) / (b + w)) % 4;
    exp_fs[u]  = (p == 0 && d == 0);
    exp_ack[u] = exp_fs[u] && mpend[u];
    if (exp_ack[u]) begin mact[u] = msh[u]; mpend[u] = 0; end
    if (load) begin msh[u] = {value_in, dp_in}; mpend[u] = 1; end
    if (p == 0) mlz[u] = lz_en;
    v   = mact[u][19:4];
    dpv = mact[u][3:0];
    exp_seg[u] = 7'h7F; exp_dp[u] = 1'b1; exp_dig[u] = 4'hF;
    if (p >= b) begin
      sup = mlz[u] && d > 0 && ((v >> (4 * d)) == 16'h0);
      exp_seg[u] = sup ? 7'h7F : seg_tab[(v >> (4 * d)) & 16'hF];
      exp_dp[u]  = ~dpv[d];
      if (!sup || dpv[d]) exp_dig[u][d] = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("seg_b2",   8'(seg0), 8'(exp_seg[0]));
    chk("dp_b2",    8'(dp0),  8'(exp_dp[0]));
    chk("digit_b2", 8'(dig0), 8'(exp_dig[0]));
    chk("ack_b2",   8'(ack0), 8'(exp_ack[0]));
    chk("fs_b2",    8'(fs0),  8'(exp_fs[0]));
    chk("seg_b0",   8'(seg1), 8'(exp_seg[1]));
    chk("dp_b0",    8'(dp1),  8'(exp_dp[1]));
    chk("digit_b0", 8'(dig1), 8'(exp_dig[1]));
    chk("ack_b0",   8'(ack1), 8'(exp_ack[1]));
    chk("fs_b0",    8'(fs1),  8'(exp_fs[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, 2, 4);
    model_step(1, 0, 1);
    #1;
    check_all();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    value_in = v; dp_in = dp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advance until the reference is at edge count k with (k mod 24) == target
  task automatic run_to(input int target);
    int n;
    n = 0;
    while ((mk[0] % 24) != target && n < 100) begin tick(); n++; end
    chk("run_to_bound", 8'((mk[0] % 24) == target), 8'd1);
  endtask

  initial begin
    rst_n = 1'b0; value_in = '0; dp_in = '0; lz_en = 1'b0; load = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle frames: all digits show '0'
    repeat (48) tick();

    // Mid-frame load commits at next frame start
    run_to(10);
    pulse_load(16'h12AF, 4'h0);
    repeat (40) tick();
    chk("show_F_after_commit", 8'(mact[0][7:4]), 8'hF);

    // Two loads in one frame, latest wins
    run_to(3);
    pulse_load(16'h1111, 4'h0);
    repeat (5) tick();
    pulse_load(16'h2222, 4'h0);
    repeat (40) tick();

    // Load on the commit cycle: old commits now, new one frame later
    run_to(5);
    pulse_load(16'h3333, 4'h0);
    run_to(0);
    pulse_load(16'h4444, 4'h0);
    repeat (50) tick();

    // Leading-zero suppression, then dp forcing digit 3 select
    lz_en = 1'b1;
    pulse_load(16'h0050, 4'h0);
    repeat (50) tick();
    pulse_load(16'h0050, 4'b1000);
    repeat (50) tick();

    // Async reset during digit-2 drive with a load pending
    run_to(12);
    pulse_load(16'hBEEF, 4'h5);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1; check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (48) tick();
    lz_en = 1'b0;
    repeat (30) tick();

    // Randomized loads, dp and lz_en changes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) begin
        value_in = 16'($urandom) & (($urandom_range(1) == 0) ? 16'h00FF : 16'hFFFF);
        dp_in    = 4'($urandom);
        load     = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(19) == 0) lz_en = ~lz_en;
      tick();
    end
    load = 1'b0;
    repeat (30) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
